se: RTL and testbench

Instruction-store block for the single-cycle/multicycle CPU datapath. It holds a 32-entry × 32-bit program memory addressed by the fetch address `adressIM` and returns the addressed instruction word on `inst`. The read is registered, so the memory sits between the PC register and the decode stage. An optional write port lets the bench or a boot loader overwrite the program.

---
 rtl/se_pkg.sv | 20 ++
 rtl/se_mem.sv | 57 +++++
 rtl/se.sv | 55 +++++
 tb/tb_se.sv | 114 +++++++++++
 4 files changed

// File: rtl/se_pkg.sv
// se_pkg: shared constants and the power-up program contents of the
// instruction store. The optional write port is enabled by defining SE_WRITE_EN.
package se_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic [DATA_W-1:0] NOP_WORD = 32'h0000_0000;
  localparam logic [5:0]        ADDI_OPC = 6'b001000;

  // Power-up word for entry i: "addi $i, $zero, i"
  // (opcode | rs=0 | rt=i | imm=i, zero-extended).
  function automatic logic [DATA_W-1:0] default_word(input int i);
    logic [4:0] r;
    r = i[4:0];
    return {ADDI_OPC, 5'b00000, r, 11'b000_0000_0000, r};
  endfunction

endpackage

// File: rtl/se_mem.sv
// se_mem: storage array of the instruction store. With SE_WRITE_EN undefined
// it is a constant ROM of the default program; with SE_WRITE_EN defined it is
// a RAM pre-loaded with the default program plus one synchronous write port.
// The read is combinational; the caller registers it, so a same-address
// write is seen read-first.
module se_mem #(
  parameter int ADDR_W = se_pkg::ADDR_W,
  parameter int DATA_W = se_pkg::DATA_W
) (
`ifdef SE_WRITE_EN
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
`endif
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  import se_pkg::*;

  localparam int WORDS = 2 ** ADDR_W;

`ifdef SE_WRITE_EN
  typedef logic [DATA_W-1:0] mem_t [WORDS];

  // Builds the elaboration-time image of the default program.
  function automatic mem_t init_contents();
    mem_t m;
    for (int i = 0; i < WORDS; i++) begin
      m[i] = DATA_W'(default_word(i));
    end
    return m;
  endfunction

  // Contents come from the initializer only; reset never touches them.
  mem_t mem = init_contents();

  // Write port: one word per rising edge when the (reset-qualified) strobe is set.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read of the addressed word (old value on a same-edge write).
  always_comb begin
    rdata = mem[raddr];
  end
`else
  // Constant ROM: the word is a pure function of the address.
  always_comb begin
    rdata = DATA_W'(default_word(int'(raddr)));
  end
`endif

endmodule

// File: rtl/se.sv
// se: instruction store with a registered read port. Fetch address in,
// instruction word out one clock later; synchronous reset forces a NOP.
// Define SE_WRITE_EN to add the we/waddr/wdata program-load port.
module se #(
  parameter int ADDR_W = se_pkg::ADDR_W,
  parameter int DATA_W = se_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] adressIM,
`ifdef SE_WRITE_EN
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
`endif
  output logic [DATA_W-1:0] inst
);

  import se_pkg::*;

  logic [DATA_W-1:0] rdata;

`ifdef SE_WRITE_EN
  logic wen;

  // Writes are suppressed on reset edges.
  always_comb begin
    wen = we & ~rst;
  end
`endif

  se_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
`ifdef SE_WRITE_EN
    .clk   (clk),
    .we    (wen),
    .waddr (waddr),
    .wdata (wdata),
`endif
    .raddr (adressIM),
    .rdata (rdata)
  );

  // Output register: NOP while in reset, otherwise the fetched word.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst <= DATA_W'(NOP_WORD);
    end else begin
      inst <= rdata;
    end
  end

endmodule

// File: tb/tb_se.sv
// tb_se: directed and randomized bench for se against a simple array model
// of the program memory. Works with and without SE_WRITE_EN.
module tb_se;

  logic        clk;
  logic        rst;
  logic [4:0]  adressIM;
  logic [31:0] inst;
`ifdef SE_WRITE_EN
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
`endif

  int total_cnt = 0;
  int pass_cnt  = 0;

  logic [31:0] model [32];

  se dut (
    .clk      (clk),
    .rst      (rst),
    .adressIM (adressIM),
`ifdef SE_WRITE_EN
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
`endif
    .inst     (inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive inputs, predict, take the edge, update model, check.
  task automatic step(input logic r, input logic [4:0] a, input string tag);
    logic [31:0] exp;
    rst      = r;
    adressIM = a;
    exp = r ? 32'h0000_0000 : model[a];
    @(posedge clk);
    #1;
`ifdef SE_WRITE_EN
    if (we && !r) model[waddr] = wdata;
`endif
    total_cnt++;
    assert (inst === exp) pass_cnt++;
    else $error("FAIL %s: addr=%0d rst=%0b inst=%h expected=%h", tag, a, r, inst, exp);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      model[i] = 32'h2000_0000 | (32'(i) << 16) | 32'(i);
    end
    rst = 1'b1;
    adressIM = 5'd17;
`ifdef SE_WRITE_EN
    we = 1'b0;
    waddr = 5'd0;
    wdata = 32'h0000_0000;
`endif

    // Reset held for two edges
    step(1'b1, 5'd17, "reset0");
    step(1'b1, 5'd17, "reset1");

    // First fetch after release
    step(1'b0, 5'd17, "fetch17");

    // Full sweep, endpoints included
    for (int i = 0; i < 32; i++) step(1'b0, 5'(i), "sweep");

    // Reset mid-stream then resume
    step(1'b0, 5'd3,  "pre_rst");
    step(1'b1, 5'd31, "mid_rst");
    step(1'b0, 5'd31, "resume31");
    step(1'b0, 5'd0,  "resume0");

`ifdef SE_WRITE_EN
    // Same-address read/write: read-first, then new data
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    step(1'b0, 5'd5, "rdw_old");
    we = 1'b0;
    step(1'b0, 5'd5, "rdw_new");

    // Write strobe during reset must be ignored
    we = 1'b1; waddr = 5'd6; wdata = 32'h1234_5678;
    step(1'b1, 5'd6, "we_in_rst");
    we = 1'b0;
    step(1'b0, 5'd6, "after_we_rst");

    // Randomized writes and reads
    for (int i = 0; i < 80; i++) begin
      we    = ($urandom_range(0, 2) == 0);
      waddr = 5'($urandom_range(0, 31));
      wdata = $urandom;
      step(($urandom_range(0, 9) == 0), 5'($urandom_range(0, 31)), "rand_wr");
    end
    we = 1'b0;
`endif

    // Randomized reads with occasional reset
    for (int i = 0; i < 80; i++) begin
      step(($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)), "rand_rd");
    end

    // Contents survive resets: sweep again
    for (int i = 0; i < 32; i++) step(1'b0, 5'(i), "resweep");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
